// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the debounce/tick sources and the mode sequencer.
// slave: the sequencer side; master: the side driving buttons and ticks.
interface time_set_ctrl_if;
  logic       mode_button;
  logic       add_button;
  logic       sub_button;
  logic       pulse_1hz;
  logic       pulse_500ms;
  logic       run_en;
  logic [1:0] field_sel;
  logic       inc_o;
  logic       dec_o;
  logic [7:0] blink_mask;

  modport slave (
    input  mode_button, add_button, sub_button, pulse_1hz, pulse_500ms,
    output run_en, field_sel, inc_o, dec_o, blink_mask
  );

  modport master (
    output mode_button, add_button, sub_button, pulse_1hz, pulse_500ms,
    input  run_en, field_sel, inc_o, dec_o, blink_mask
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Mode sequencer for the clock: RUN / set-hours / set-minutes / set-seconds,
// add/sub strobes with hold-to-repeat, set-state timeout and digit blinking.
// All outputs are registered; every response appears one cycle after the
// press edge that caused it.
module time_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter int unsigned TIMEOUT_S    = 30
) (
  input  logic           clock,
  input  logic           reset,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCW     = $clog2(RPT_MAX + 1);
  localparam int unsigned TCW     = $clog2(TIMEOUT_S + 1);

  localparam logic [RCW-1:0] DELAY_C  = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] RATE_C   = RCW'(REPEAT_RATE);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RPT_NONE = 2'd0,
    RPT_ADD  = 2'd1,
    RPT_SUB  = 2'd2
  } rpt_t;

  state_t         state_q, state_d;
  rpt_t           rpt_q, rpt_d;
  logic [RCW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_nx, rpt_target;
  logic           rpt_first_q, rpt_first_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           tmo_fire;
  logic           phase_q, phase_d;
  logic           mode_h_q, add_h_q, sub_h_q;
  logic           inc_q, inc_d, dec_q, dec_d;
  logic           run_en_q, run_en_d;
  logic [7:0]     mask_q, mask_d;

  logic mode_e, add_e, sub_e, any_edge, in_set, both_held, rpt_hold;

  assign mode_e    = bus.mode_button & ~mode_h_q;
  assign add_e     = bus.add_button  & ~add_h_q;
  assign sub_e     = bus.sub_button  & ~sub_h_q;
  assign any_edge  = mode_e | add_e | sub_e;
  assign in_set    = (state_q != RUN);
  assign both_held = bus.add_button & bus.sub_button;
  assign rpt_hold  = ((rpt_q == RPT_ADD) && bus.add_button) ||
                     ((rpt_q == RPT_SUB) && bus.sub_button);
  assign rpt_target = rpt_first_q ? DELAY_C : RATE_C;

  // Next-state, strobe, repeat, timeout and blink decisions.
  always_comb begin
    state_d     = state_q;
    rpt_d       = RPT_NONE;
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_cnt_nx  = rpt_cnt_q + RCW'(1);
    tmo_d       = tmo_q;
    tmo_fire    = 1'b0;
    phase_d     = phase_q;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    run_en_d    = 1'b1;
    mask_d      = '0;

    // Mode edge beats timeout; an edge of any button also restarts the timeout.
    if (mode_e) begin
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        default: state_d = RUN;
      endcase
    end else if (in_set && bus.pulse_1hz && !any_edge && (tmo_q == TMO_LAST)) begin
      tmo_fire = 1'b1;
      state_d  = RUN;
    end

    // Strobes only in set states; a conflict or a field change drops the repeat.
    if (in_set && !mode_e && !tmo_fire && !both_held) begin
      if (add_e) begin
        inc_d = 1'b1;
        rpt_d = RPT_ADD;
      end else if (sub_e) begin
        dec_d = 1'b1;
        rpt_d = RPT_SUB;
      end else if (rpt_hold) begin
        rpt_d = rpt_q;
        if (rpt_cnt_nx == rpt_target) begin
          inc_d       = (rpt_q == RPT_ADD);
          dec_d       = (rpt_q == RPT_SUB);
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d   = rpt_cnt_nx;
          rpt_first_d = rpt_first_q;
        end
      end
    end

    if (!in_set || (state_d != state_q) || any_edge) begin
      tmo_d = '0;
    end else if (bus.pulse_1hz) begin
      tmo_d = tmo_q + TCW'(1);
    end

    if ((state_d == RUN) || (state_d != state_q) || inc_d || dec_d) begin
      phase_d = 1'b0;
    end else if (bus.pulse_500ms) begin
      phase_d = ~phase_q;
    end

    run_en_d = (state_d == RUN);
    if (phase_d) begin
      case (state_d)
        SET_HH:  mask_d = 8'b0011_0000;
        SET_MM:  mask_d = 8'b0000_1100;
        SET_SS:  mask_d = 8'b0000_0011;
        default: mask_d = '0;
      endcase
    end
  end

  // State, counters, button history and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      rpt_q       <= RPT_NONE;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      tmo_q       <= '0;
      phase_q     <= 1'b0;
      mode_h_q    <= 1'b1;
      add_h_q     <= 1'b1;
      sub_h_q     <= 1'b1;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      run_en_q    <= 1'b1;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      rpt_q       <= rpt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      tmo_q       <= tmo_d;
      phase_q     <= phase_d;
      mode_h_q    <= bus.mode_button;
      add_h_q     <= bus.add_button;
      sub_h_q     <= bus.sub_button;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      run_en_q    <= run_en_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.run_en     = run_en_q;
  assign bus.field_sel  = state_q;
  assign bus.inc_o      = inc_q;
  assign bus.dec_o      = dec_q;
  assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short repeat/timeout parameters.
// Observations are taken 1 ns after each rising edge, so one tick after
// driving a press edge shows the N+1 response.
module tb_time_set_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  time_set_ctrl_if ifc();

  time_set_ctrl #(
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5),
    .TIMEOUT_S   (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Press mode for one cycle and check the field/run_en response at N+1.
  task automatic mode_tap(input logic [1:0] exp_field, input logic exp_run);
    ifc.mode_button = 1'b1;
    tick();
    check("mode_field", 32'(ifc.field_sel), 32'(exp_field));
    check("mode_run_en", 32'(ifc.run_en), 32'(exp_run));
    ifc.mode_button = 1'b0;
    tick();
  endtask

  task automatic pulse_1hz_once();
    ifc.pulse_1hz = 1'b1;
    tick();
    ifc.pulse_1hz = 1'b0;
  endtask

  initial begin
    int strobes;
    logic exp_inc;

    ifc.mode_button = 1'b0;
    ifc.add_button  = 1'b0;
    ifc.sub_button  = 1'b0;
    ifc.pulse_1hz   = 1'b0;
    ifc.pulse_500ms = 1'b0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_run_en", 32'(ifc.run_en), 32'd1);
    check("rst_field", 32'(ifc.field_sel), 32'd0);
    check("rst_inc", 32'(ifc.inc_o), 32'd0);
    check("rst_dec", 32'(ifc.dec_o), 32'd0);
    check("rst_mask", 32'(ifc.blink_mask), 32'h00);

    // Full mode cycle
    mode_tap(2'd1, 1'b0);
    check("hh_held_run_en", 32'(ifc.run_en), 32'd0);
    mode_tap(2'd2, 1'b0);
    mode_tap(2'd3, 1'b0);
    mode_tap(2'd0, 1'b1);

    // Taps in SET_MM
    mode_tap(2'd1, 1'b0);
    mode_tap(2'd2, 1'b0);
    ifc.add_button = 1'b1;
    tick();
    check("mm_add_inc", 32'(ifc.inc_o), 32'd1);
    check("mm_add_dec", 32'(ifc.dec_o), 32'd0);
    ifc.add_button = 1'b0;
    tick();
    check("mm_add_inc_once", 32'(ifc.inc_o), 32'd0);
    ifc.sub_button = 1'b1;
    tick();
    check("mm_sub_dec", 32'(ifc.dec_o), 32'd1);
    check("mm_sub_inc", 32'(ifc.inc_o), 32'd0);
    ifc.sub_button = 1'b0;
    tick();
    check("mm_sub_dec_once", 32'(ifc.dec_o), 32'd0);

    // Same taps in RUN give nothing
    mode_tap(2'd3, 1'b0);
    mode_tap(2'd0, 1'b1);
    ifc.add_button = 1'b1;
    tick();
    check("run_add_inc", 32'(ifc.inc_o), 32'd0);
    ifc.add_button = 1'b0;
    ifc.sub_button = 1'b1;
    tick();
    check("run_sub_dec", 32'(ifc.dec_o), 32'd0);
    ifc.sub_button = 1'b0;
    tick();

    // Hold-to-repeat in SET_HH: strobes at N+1, 21, 26, 31, 36, 41
    mode_tap(2'd1, 1'b0);
    ifc.add_button = 1'b1;
    strobes = 0;
    for (int k = 1; k <= 41; k++) begin
      tick();
      exp_inc = (k == 1 || k == 21 || k == 26 || k == 31 || k == 36 || k == 41);
      check($sformatf("rpt_inc_k%0d", k), 32'(ifc.inc_o), 32'(exp_inc));
      if (ifc.inc_o) strobes++;
    end
    check("rpt_total", 32'(strobes), 32'd6);
    ifc.add_button = 1'b0;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ifc.inc_o || ifc.dec_o) strobes++;
    end
    check("rpt_release", 32'(strobes), 32'd0);

    // Add held, sub raised then released: no more strobes until re-press
    ifc.add_button = 1'b1;
    tick();
    check("conf_first_inc", 32'(ifc.inc_o), 32'd1);
    ifc.sub_button = 1'b1;
    tick();
    check("conf_sub_dec", 32'(ifc.dec_o), 32'd0);
    check("conf_sub_inc", 32'(ifc.inc_o), 32'd0);
    ifc.sub_button = 1'b0;
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ifc.inc_o || ifc.dec_o) strobes++;
    end
    check("conf_held_none", 32'(strobes), 32'd0);
    ifc.add_button = 1'b0;
    tick();
    ifc.add_button = 1'b1;
    tick();
    check("conf_repress_inc", 32'(ifc.inc_o), 32'd1);
    ifc.add_button = 1'b0;
    tick();

    // Same-cycle add+sub edges
    ifc.add_button = 1'b1;
    ifc.sub_button = 1'b1;
    strobes = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (ifc.inc_o || ifc.dec_o) strobes++;
    end
    check("both_none", 32'(strobes), 32'd0);
    ifc.add_button = 1'b0;
    ifc.sub_button = 1'b0;
    tick();

    // Timeout in SET_SS after 3 seconds
    mode_tap(2'd2, 1'b0);
    mode_tap(2'd3, 1'b0);
    pulse_1hz_once();
    tick();
    check("tmo_1_field", 32'(ifc.field_sel), 32'd3);
    pulse_1hz_once();
    tick();
    check("tmo_2_field", 32'(ifc.field_sel), 32'd3);
    pulse_1hz_once();
    check("tmo_3_field", 32'(ifc.field_sel), 32'd0);
    check("tmo_3_run_en", 32'(ifc.run_en), 32'd1);
    tick();

    // Mode edge coincident with the 3rd pulse wins
    mode_tap(2'd1, 1'b0);
    pulse_1hz_once();
    tick();
    pulse_1hz_once();
    tick();
    ifc.pulse_1hz   = 1'b1;
    ifc.mode_button = 1'b1;
    tick();
    check("tmo_mode_field", 32'(ifc.field_sel), 32'd2);
    check("tmo_mode_run_en", 32'(ifc.run_en), 32'd0);
    ifc.pulse_1hz   = 1'b0;
    ifc.mode_button = 1'b0;
    tick();
    check("tmo_mode_stay", 32'(ifc.field_sel), 32'd2);

    // Blink in SET_HH
    mode_tap(2'd3, 1'b0);
    mode_tap(2'd0, 1'b1);
    mode_tap(2'd1, 1'b0);
    check("blink_entry", 32'(ifc.blink_mask), 32'h00);
    ifc.pulse_500ms = 1'b1;
    tick();
    check("blink_on", 32'(ifc.blink_mask), 32'h30);
    ifc.pulse_500ms = 1'b0;
    tick();
    check("blink_hold", 32'(ifc.blink_mask), 32'h30);
    ifc.pulse_500ms = 1'b1;
    tick();
    check("blink_off", 32'(ifc.blink_mask), 32'h00);
    tick();
    check("blink_on2", 32'(ifc.blink_mask), 32'h30);
    ifc.pulse_500ms = 1'b0;
    ifc.add_button  = 1'b1;
    tick();
    check("blink_strobe_inc", 32'(ifc.inc_o), 32'd1);
    check("blink_strobe_mask", 32'(ifc.blink_mask), 32'h00);

    // Reset asserted mid-repeat, add still held
    for (int k = 0; k < 22; k++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_run_en", 32'(ifc.run_en), 32'd1);
    check("mid_rst_field", 32'(ifc.field_sel), 32'd0);
    check("mid_rst_inc", 32'(ifc.inc_o), 32'd0);
    check("mid_rst_dec", 32'(ifc.dec_o), 32'd0);
    check("mid_rst_mask", 32'(ifc.blink_mask), 32'h00);
    reset = 1'b0;
    tick();
    check("post_rst_inc", 32'(ifc.inc_o), 32'd0);
    check("post_rst_field", 32'(ifc.field_sel), 32'd0);
    ifc.add_button = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Mode sequencer for the timekeeping datapath. Takes the debounced mode, add and sub buttons plus the 1 Hz and 500 ms tick pulses.
- Outputs:
  - count-enable for the HH:MM:SS counter;
  - the selected field;
  - single-cycle increment/decrement strobes, with hold-to-repeat;
  - per-digit blink mask for the display driver.
- Sits between the debounce instances and the time counter/display formatting logic.

Parameters:
REPEAT_DELAY, 50000000, clock cycles a button must stay held after its press edge before the first auto-repeat strobe
REPEAT_RATE, 10000000, clock cycles between auto-repeat strobes (must be >= 2)
TIMEOUT_S, 30, seconds without a button edge in a set state before returning to RUN (must be >= 1)

Ports:
clock  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
mode_button  in  1  debounced mode button level
add_button  in  1  debounced add button level
sub_button  in  1  debounced sub button level
pulse_1hz  in  1  one-cycle pulse, 1 Hz
pulse_500ms  in  1  one-cycle pulse every 500 ms
run_en  out  1  1 = time counter advances on pulse_1hz
field_sel  out  2  0 none, 1 hours, 2 minutes, 3 seconds
inc_o  out  1  one-cycle increment strobe for the selected field
dec_o  out  1  one-cycle decrement strobe for the selected field
blink_mask  out  8  bit i = 1 blanks display digit d(i+1)

Behaviour:
- Reset, synchronous and active-high; all outputs registered:
  - state RUN, run_en=1, field_sel=0, inc_o=0, dec_o=0, blink_mask=0;
  - blink phase=0, repeat and timeout counters=0;
  - button history registers=1, so a button held through reset gives no edge.
- Edge detect:
  - A press edge is cycle N, where the level=1 and its history=0.
  - Every response (state change, strobe) appears at N+1.
- Mode FSM, transitions on a mode press edge:
  - RUN -> SET_HH -> SET_MM -> SET_SS -> RUN.
  - field_sel: RUN 0, SET_HH 1, SET_MM 2, SET_SS 3.
  - run_en = 1 only in RUN; it drops at N+1 on entering SET_HH and returns at N+1 on leaving SET_SS.
- Timeout:
  - In set states, pulse_1hz increments the timeout counter.
  - The counter clears on any button press edge or state change.
  - When the counter reaches TIMEOUT_S, go to RUN next cycle.
  - Mode edge and timeout in the same cycle: the mode edge wins (normal advance).
- Strobes, set states only; add/sub ignored in RUN:
  - add press edge -> inc_o=1 at N+1 for exactly one cycle.
  - sub press edge -> dec_o=1 at N+1 for exactly one cycle.
  - inc_o and dec_o are never both 1.
- Auto-repeat:
  - While the initiating button stays held with no other button pressed, the repeat counter counts cycles from N+1.
  - First repeat strobe at N+1+REPEAT_DELAY, then every REPEAT_RATE cycles.
  - Releasing the button clears the counter; no strobe on release.
- Simultaneous and conflicting buttons:
  - add and sub both at 1, whether same-cycle edges or one rising while the other is held: no strobe, repeat cleared.
  - A new strobe requires a fresh press edge after both are released.
  - A mode edge has priority: in that cycle add/sub edges are discarded and any repeat stops.
  - The new field requires a fresh add/sub edge.
- Blink:
  - The phase toggles on each pulse_500ms while in a set state.
  - The phase is forced to 0 on entering a set state and in any cycle that issues inc_o or dec_o, keeping the value visible while adjusting.
  - blink_mask = phase ? field mask : 0.
  - Field masks: hours 8'b0011_0000, minutes 8'b0000_1100, seconds 8'b0000_0011.
  - RUN: blink_mask = 0.
- Reset mid-operation (any state, any repeat in progress) returns to the reset values on the next clock edge. No strobe is emitted in the reset cycle or the cycle after.

Test Plan (REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT_S=3):
- Reset, then mode edges x4 -> field_sel 1,2,3,0, each change at N+1; run_en=0 from 1st edge until the 4th edge's N+1.
- In SET_MM, tap add 1 cycle and sub 1 cycle -> exactly one inc_o pulse and one dec_o pulse at N+1; in RUN the same taps -> no strobes.
- In SET_HH, hold add 40 cycles -> strobes at N+1, N+21, N+26, N+31, N+36, N+41 (6 total); then release -> none.
- Hold add while raising sub, then release sub -> no further strobes until add is released and re-pressed; same-cycle add+sub edges -> no strobe.
- In SET_SS, 3 pulse_1hz with no buttons -> RUN on the cycle after the 3rd pulse, run_en=1. With a mode edge coincident with the 3rd pulse in SET_HH -> SET_MM.
- In SET_HH, pulse_500ms x2 -> blink_mask 8'h30 then 8'h00. An add strobe while blanked -> mask 8'h00 the same cycle. Reset asserted mid-repeat -> all outputs at reset values, no strobe.
